// File: rtl/alu.sv
// RV32I execute-stage ALU: operand select, arithmetic/logic/shift/compare,
// with a one-cycle registered result and branch-taken flag.
`ifndef ALU_ADD
`define ALU_ADD  6'd8
`define ALU_SUB  6'd9
`define ALU_SLT  6'd10
`define ALU_SLTU 6'd11
`define ALU_XOR  6'd12
`define ALU_OR   6'd13
`define ALU_AND  6'd14
`define ALU_SLL  6'd15
`define ALU_SRL  6'd16
`define ALU_SRA  6'd17
`define ALU_LUI  6'd18
`define ALU_JAL  6'd19
`define ALU_JALR 6'd20
`define ALU_BEQ  6'd21
`define ALU_BNE  6'd22
`define ALU_BLT  6'd23
`define ALU_BGE  6'd24
`define ALU_BLTU 6'd25
`define ALU_BGEU 6'd26
`endif

module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  alucode,
    input  logic [31:0] r1,
    input  logic [31:0] r2,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    input  logic        using_r2,
    input  logic        using_pc,
    output logic [31:0] alu_result,
    output logic        br
);

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] result_d, result_q;
    logic        br_d, br_q;

    always_comb begin
        op_a     = using_pc ? pc : r1;
        op_b     = using_r2 ? r2 : imm;
        shamt    = op_b[4:0];
        result_d = '0;
        br_d     = 1'b0;
        case (alucode)
            `ALU_ADD:  result_d = op_a + op_b;
            `ALU_SUB:  result_d = op_a - op_b;
            `ALU_SLT:  result_d = {31'd0, $signed(op_a) < $signed(op_b)};
            `ALU_SLTU: result_d = {31'd0, op_a < op_b};
            `ALU_XOR:  result_d = op_a ^ op_b;
            `ALU_OR:   result_d = op_a | op_b;
            `ALU_AND:  result_d = op_a & op_b;
            `ALU_SLL:  result_d = op_a << shamt;
            `ALU_SRL:  result_d = op_a >> shamt;
            `ALU_SRA:  result_d = $unsigned($signed(op_a) >>> shamt);
            `ALU_LUI:  result_d = op_b;
            `ALU_JAL, `ALU_JALR: begin
                result_d = pc + 32'd4;
                br_d     = 1'b1;
            end
            `ALU_BEQ:  br_d = (op_a == op_b);
            `ALU_BNE:  br_d = (op_a != op_b);
            `ALU_BLT:  br_d = ($signed(op_a) < $signed(op_b));
            `ALU_BGE:  br_d = ($signed(op_a) >= $signed(op_b));
            `ALU_BLTU: br_d = (op_a < op_b);
            `ALU_BGEU: br_d = (op_a >= op_b);
            default: begin
                result_d = '0;
                br_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            br_q     <= 1'b0;
        end else begin
            result_q <= result_d;
            br_q     <= br_d;
        end
    end

    assign alu_result = result_q;
    assign br         = br_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, hand-written timing
// sequences, and randomized operations against a behavioural model.
`ifndef ALU_ADD
`define ALU_ADD  6'd8
`define ALU_SUB  6'd9
`define ALU_SLT  6'd10
`define ALU_SLTU 6'd11
`define ALU_XOR  6'd12
`define ALU_OR   6'd13
`define ALU_AND  6'd14
`define ALU_SLL  6'd15
`define ALU_SRL  6'd16
`define ALU_SRA  6'd17
`define ALU_LUI  6'd18
`define ALU_JAL  6'd19
`define ALU_JALR 6'd20
`define ALU_BEQ  6'd21
`define ALU_BNE  6'd22
`define ALU_BLT  6'd23
`define ALU_BGE  6'd24
`define ALU_BLTU 6'd25
`define ALU_BGEU 6'd26
`endif

module tb_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  alucode = '0;
    logic [31:0] r1 = '0, r2 = '0, imm = '0, pc = '0;
    logic        using_r2 = 1'b1, using_pc = 1'b0;
    logic [31:0] alu_result;
    logic        br;

    int tests = 0;
    int fails = 0;

    alu dut (
        .clk(clk), .rst_n(rst_n), .alucode(alucode),
        .r1(r1), .r2(r2), .imm(imm), .pc(pc),
        .using_r2(using_r2), .using_pc(using_pc),
        .alu_result(alu_result), .br(br)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] r1, r2, imm, pc;
        logic        u_r2, u_pc;
        logic [31:0] exp_res;
        logic        exp_br;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] res_exp, input logic br_exp);
        tests++;
        if (alu_result !== res_exp || br !== br_exp) begin
            fails++;
            $display("FAIL %s: got result=%h br=%b, expected result=%h br=%b",
                     name, alu_result, br, res_exp, br_exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] im, input logic [31:0] p,
                         input logic ur2, input logic upc);
        alucode = op; r1 = a1; r2 = a2; imm = im; pc = p;
        using_r2 = ur2; using_pc = upc;
    endtask

    // Reference model from the ISA rules, using wide integer arithmetic.
    function automatic void model(input logic [5:0] op, input logic [31:0] a1, input logic [31:0] a2,
                                  input logic [31:0] im, input logic [31:0] p,
                                  input logic ur2, input logic upc,
                                  output logic [31:0] res, output logic brf);
        longint ua, ub, sa, sb;
        int     sh;
        ua = upc ? {32'd0, p} : {32'd0, a1};
        ub = ur2 ? {32'd0, a2} : {32'd0, im};
        sa = (ua >= 64'h8000_0000) ? ua - 64'h1_0000_0000 : ua;
        sb = (ub >= 64'h8000_0000) ? ub - 64'h1_0000_0000 : ub;
        sh = int'(ub % 32);
        res = '0;
        brf = 1'b0;
        case (op)
            `ALU_ADD:  res = 32'((ua + ub) % 64'h1_0000_0000);
            `ALU_SUB:  res = 32'((ua - ub + 64'h1_0000_0000) % 64'h1_0000_0000);
            `ALU_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
            `ALU_SLTU: res = (ua < ub) ? 32'd1 : 32'd0;
            `ALU_XOR:  res = 32'(ua) ^ 32'(ub);
            `ALU_OR:   res = 32'(ua) | 32'(ub);
            `ALU_AND:  res = 32'(ua) & 32'(ub);
            `ALU_SLL:  res = 32'((ua * (64'd1 << sh)) % 64'h1_0000_0000);
            `ALU_SRL:  res = 32'(ua / (64'd1 << sh));
            `ALU_SRA: begin
                // floor division of the signed value by 2^sh
                longint q;
                q = sa / (64'sd1 <<< sh);
                if (sa < 0 && (q * (64'sd1 <<< sh)) != sa) q = q - 1;
                res = 32'((q + 64'h1_0000_0000) % 64'h1_0000_0000);
            end
            `ALU_LUI:  res = 32'(ub);
            `ALU_JAL, `ALU_JALR: begin
                res = 32'(({32'd0, p} + 64'd4) % 64'h1_0000_0000);
                brf = 1'b1;
            end
            `ALU_BEQ:  brf = (ua == ub);
            `ALU_BNE:  brf = (ua != ub);
            `ALU_BLT:  brf = (sa < sb);
            `ALU_BGE:  brf = (sa >= sb);
            `ALU_BLTU: brf = (ua < ub);
            `ALU_BGEU: brf = (ua >= ub);
            default: ;
        endcase
    endfunction

    initial begin
        logic [31:0] er;
        logic        eb;
        logic [5:0]  ops[$];

        vecs.push_back('{"add",    `ALU_ADD,  32'd34, 32'd55, 0, 0, 1, 0, 32'd89, 0});
        vecs.push_back('{"sub",    `ALU_SUB,  32'd55, 32'd56, 0, 0, 1, 0, 32'hFFFFFFFF, 0});
        vecs.push_back('{"slt",    `ALU_SLT,  32'hFEEDFACE, 32'hBADCAB1E, 0, 0, 1, 0, 32'd0, 0});
        vecs.push_back('{"sltu",   `ALU_SLTU, 32'hBADCAB1E, 32'hFEEDFACE, 0, 0, 1, 0, 32'd1, 0});
        vecs.push_back('{"xor",    `ALU_XOR,  32'hBADCAB1E, 32'hFEEDFACE, 0, 0, 1, 0, 32'h443151D0, 0});
        vecs.push_back('{"or",     `ALU_OR,   32'hBADCAB1E, 32'hFEEDFACE, 0, 0, 1, 0, 32'hFEFDFBDE, 0});
        vecs.push_back('{"and",    `ALU_AND,  32'hBADCAB1E, 32'hFEEDFACE, 0, 0, 1, 0, 32'hBACCAA0E, 0});
        vecs.push_back('{"sll",    `ALU_SLL,  32'hFEEDFACE, 32'd1036, 0, 0, 1, 0, 32'hDFACE000, 0});
        vecs.push_back('{"srl",    `ALU_SRL,  32'hDEADDEAD, 32'd16, 0, 0, 1, 0, 32'h0000DEAD, 0});
        vecs.push_back('{"sra",    `ALU_SRA,  32'hDEADDEAD, 32'd16, 0, 0, 1, 0, 32'hFFFFDEAD, 0});
        vecs.push_back('{"pc_imm", `ALU_ADD,  32'd7, 32'd9, 32'h20, 32'h100, 0, 1, 32'h120, 0});
        vecs.push_back('{"lui",    `ALU_LUI,  32'h1234, 32'd0, 32'hABCDE000, 0, 0, 0, 32'hABCDE000, 0});
        vecs.push_back('{"blt",    `ALU_BLT,  32'hFFFFFFFF, 32'd1, 0, 0, 1, 0, 32'd0, 1});
        vecs.push_back('{"bltu",   `ALU_BLTU, 32'hFFFFFFFF, 32'd1, 0, 0, 1, 0, 32'd0, 0});
        vecs.push_back('{"beq",    `ALU_BEQ,  32'd5, 32'd5, 0, 0, 1, 0, 32'd0, 1});
        vecs.push_back('{"bne",    `ALU_BNE,  32'd5, 32'd5, 0, 0, 1, 0, 32'd0, 0});
        vecs.push_back('{"bge",    `ALU_BGE,  32'd1, 32'hFFFFFFFF, 0, 0, 1, 0, 32'd0, 1});
        vecs.push_back('{"bgeu",   `ALU_BGEU, 32'd1, 32'hFFFFFFFF, 0, 0, 1, 0, 32'd0, 0});
        vecs.push_back('{"jal",    `ALU_JAL,  32'd3, 32'd4, 32'h8, 32'h40, 1, 0, 32'h44, 1});
        vecs.push_back('{"jalr",   `ALU_JALR, 32'd3, 32'd4, 32'h8, 32'hFFFFFFFC, 0, 0, 32'h0, 1});
        vecs.push_back('{"undef",  6'd63,     32'd3, 32'd4, 0, 0, 1, 0, 32'd0, 0});

        // Reset held: outputs stay zero across edges.
        drive(`ALU_ADD, 32'd1, 32'd1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", 32'd0, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release", 32'd2, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].r1, vecs[i].r2, vecs[i].imm, vecs[i].pc,
                  vecs[i].u_r2, vecs[i].u_pc);
            @(negedge clk);
            check(vecs[i].name, vecs[i].exp_res, vecs[i].exp_br);
        end

        // Inputs changed mid-cycle must not reach the output before the edge.
        drive(`ALU_ADD, 32'd10, 32'd20, 0, 0, 1, 0);
        @(negedge clk);
        check("hold_before", 32'd30, 1'b0);
        drive(`ALU_JAL, 32'd0, 32'd0, 0, 32'h200, 1, 0);
        #2;
        check("hold_midcycle", 32'd30, 1'b0);
        @(negedge clk);
        check("hold_after", 32'h204, 1'b1);

        // Asynchronous reset pulse between edges.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_discard", 32'd0, 1'b0);
        @(negedge clk);
        check("post_reset", 32'h204, 1'b1);

        // Randomized operations including undefined codes.
        ops = '{`ALU_ADD, `ALU_SUB, `ALU_SLT, `ALU_SLTU, `ALU_XOR, `ALU_OR, `ALU_AND,
                `ALU_SLL, `ALU_SRL, `ALU_SRA, `ALU_LUI, `ALU_JAL, `ALU_JALR, `ALU_BEQ,
                `ALU_BNE, `ALU_BLT, `ALU_BGE, `ALU_BLTU, `ALU_BGEU};
        for (int i = 0; i < 400; i++) begin
            logic [5:0]  op;
            logic [31:0] a1, a2, im, p;
            logic        ur2, upc;
            if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
            else op = ops[$urandom_range(0, ops.size() - 1)];
            a1 = $urandom; a2 = $urandom; im = $urandom; p = $urandom;
            if ($urandom_range(0, 3) == 0) a2 = a1;
            ur2 = 1'($urandom_range(0, 1));
            upc = 1'($urandom_range(0, 1));
            drive(op, a1, a2, im, p, ur2, upc);
            model(op, a1, a2, im, p, ur2, upc, er, eb);
            @(negedge clk);
            check($sformatf("rand_op%0d", op), er, eb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
